// File: rtl/cga_vram_arbiter_if.sv
// rtl/cga_vram_arbiter_if.sv - ISA bus, sequencer and video RAM signals of the CGA VRAM arbiter
interface cga_vram_arbiter_if;
  // ISA side
  logic [19:0] bus_a;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_d;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;
  // Sequencer / display side
  logic        isa_op_enable;
  logic        vram_read;
  logic [18:0] video_addr;
  // RAM port
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport slave (
    input  bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    input  isa_op_enable, vram_read, video_addr, ram_din,
    output bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_dout
  );

  modport master (
    output bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
    output isa_op_enable, vram_read, video_addr, ram_din,
    input  bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_dout
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - shares the CGA video RAM port between ISA CPU cycles and display fetches
module cga_vram_arbiter #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter bit          USE_BUS_WAIT     = 1'b1
) (
  input logic            clk,
  input logic            reset_l,
  cga_vram_arbiter_if.slave io
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  state_t state, state_nxt;

  // [0],[1] are the synchronizer flops, [2] holds the previous synced value
  logic [2:0]  memr_sync, memw_sync;
  logic        fall_r, fall_w, strobes_high;
  logic        cs, start, grant;
  logic [14:0] addr_q;
  logic [7:0]  data_q;
  logic        wr_q;
  logic [7:0]  bus_out_q;
  logic        rdy_q;

  assign fall_r       = memr_sync[2] & ~memr_sync[1];
  assign fall_w       = memw_sync[2] & ~memw_sync[1];
  assign strobes_high = memr_sync[1] & memw_sync[1];

  assign cs    = (io.bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]) & ~io.bus_aen;
  assign start = (state == ST_IDLE) & (fall_r | fall_w) & cs;
  // Gated by reset_l so a slot arriving in the reset cycle never writes RAM
  assign grant = (state == ST_WAIT_SLOT) & io.isa_op_enable & ~io.vram_read & reset_l;

  // Resynchronize the asynchronous ISA strobes; reset to the inactive level
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      memr_sync <= 3'b111;
      memw_sync <= 3'b111;
    end else begin
      memr_sync <= {memr_sync[1:0], io.bus_memr_l};
      memw_sync <= {memw_sync[1:0], io.bus_memw_l};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, wait for a free slot, one RAM cycle, wait for strobe release
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_WAIT_SLOT;
      ST_WAIT_SLOT: if (grant) state_nxt = ST_ACCESS;
      ST_ACCESS:    state_nxt = ST_HOLD;
      ST_HOLD:      if (strobes_high) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Latch the CPU request at the detected edge; simultaneous strobes count as a write
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else if (start) begin
      addr_q <= io.bus_a[14:0];
      data_q <= io.bus_d;
      wr_q   <= fall_w;
    end
  end

  // Capture read data in ACCESS, one clock after the address was presented
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      bus_out_q <= 8'h00;
    end else if (state == ST_ACCESS && !wr_q) begin
      bus_out_q <= io.ram_din;
    end
  end

  // Wait-state generator: low from acceptance until HOLD is entered
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      rdy_q <= 1'b1;
    end else if (start) begin
      rdy_q <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rdy_q <= 1'b1;
    end
  end

  // The display owns the RAM port except in the single grant cycle
  assign io.ram_a    = grant ? {4'h0, addr_q} : io.video_addr;
  assign io.ram_we_l = ~(grant & wr_q);
  assign io.ram_dout = data_q;

  assign io.bus_out = bus_out_q;
  assign io.bus_rdy = USE_BUS_WAIT ? rdy_q : 1'b1;
  assign io.bus_dir = cs & ~io.bus_memr_l;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb/tb_cga_vram_arbiter.sv - scoreboard bench for cga_vram_arbiter
module tb_cga_vram_arbiter;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  cga_vram_arbiter_if vif();

  cga_vram_arbiter dut (
    .clk     (clk),
    .reset_l (reset_l),
    .io      (vif)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] ram     [0:32767];
  logic [7:0] ref_mem [0:32767];
  bit preload = 1'b1;

  logic [14:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [14:0] rd_addr_q[$];
  logic [7:0]  rd_data_q[$];
  bit rd_held = 1'b0;

  bit rand_slots = 1'b0;
  bit force_en = 1'b0;
  bit force_vr = 1'b0;
  bit prev_rdy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Synchronous RAM with one clock read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32768; i++) ram[i] <= ref_mem[i];
    end else if (!vif.ram_we_l) begin
      ram[vif.ram_a[14:0]] <= vif.ram_dout;
    end
    vif.ram_din <= ram[vif.ram_a[14:0]];
  end

  // Sequencer and display fetch stimulus
  initial begin
    vif.isa_op_enable = 1'b0;
    vif.vram_read = 1'b0;
    vif.video_addr = 19'h40000;
    forever begin
      @(posedge clk);
      #2;
      if (rand_slots) begin
        vif.isa_op_enable = ($urandom_range(0, 7) == 0);
        vif.vram_read = ($urandom_range(0, 2) == 0);
      end else begin
        vif.isa_op_enable = force_en;
        vif.vram_read = force_vr;
      end
      vif.video_addr = {1'b1, 18'($urandom)};
    end
  end

  // Monitor: any RAM cycle not on video_addr must be an expected CPU cycle in a free slot
  initial begin
    forever begin
      @(negedge clk);
      if (reset_l) begin
        if (vif.ram_a != vif.video_addr) begin
          check("grant_in_free_slot", {30'd0, vif.isa_op_enable, vif.vram_read}, 32'd2);
          if (!vif.ram_we_l) begin
            if (wr_addr_q.size() == 0) begin
              fail_event("unexpected_write");
            end else begin
              check("write_addr", vif.ram_a, {4'h0, wr_addr_q.pop_front()});
              check("write_data", vif.ram_dout, wr_data_q.pop_front());
            end
          end else begin
            if (rd_addr_q.size() == 0) fail_event("unexpected_read");
            else check("read_addr", vif.ram_a, {4'h0, rd_addr_q.pop_front()});
          end
        end else begin
          check("display_we_l", vif.ram_we_l, 1);
        end
        if (vif.bus_rdy && !prev_rdy && rd_held) begin
          if (rd_data_q.size() == 0) fail_event("unexpected_read_done");
          else check("read_data", vif.bus_out, rd_data_q.pop_front());
        end
        prev_rdy = vif.bus_rdy;
      end else begin
        prev_rdy = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input logic v, input int lim, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (vif.bus_rdy === v) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
    drive_tick(1);
  endtask

  task automatic release_strobes();
    vif.bus_memr_l = 1'b1;
    vif.bus_memw_l = 1'b1;
  endtask

  task automatic issue(input bit wr, input logic [19:0] a, input logic [7:0] d,
                       input bit aen, input bit hold, input bit both);
    bit decoded;
    bit is_wr;
    decoded = (a[19:15] == 5'b10111) && !aen;
    is_wr = wr || both;
    if (decoded) begin
      if (is_wr) begin
        wr_addr_q.push_back(a[14:0]);
        wr_data_q.push_back(d);
        ref_mem[a[14:0]] = d;
      end else begin
        rd_addr_q.push_back(a[14:0]);
        if (hold) begin
          rd_data_q.push_back(ref_mem[a[14:0]]);
          rd_held = 1'b1;
        end
      end
    end
    vif.bus_a = a;
    vif.bus_d = d;
    vif.bus_aen = aen;
    if (both) begin
      vif.bus_memr_l = 1'b0;
      vif.bus_memw_l = 1'b0;
    end else if (is_wr) begin
      vif.bus_memw_l = 1'b0;
    end else begin
      vif.bus_memr_l = 1'b0;
    end
    if (!decoded) begin
      repeat (6) begin
        @(negedge clk);
        check("nodecode_rdy", vif.bus_rdy, 1);
        check("nodecode_dir", vif.bus_dir, 0);
      end
      drive_tick(1);
      release_strobes();
    end else if (hold) begin
      wait_rdy(1'b0, 8, "rdy_low");
      wait_rdy(1'b1, 400, "rdy_return");
      release_strobes();
    end else begin
      drive_tick(2);
      release_strobes();
      wait_rdy(1'b0, 8, "early_rdy_low");
      wait_rdy(1'b1, 400, "early_rdy_return");
    end
    rd_held = 1'b0;
    vif.bus_aen = 1'b0;
    drive_tick(5);
  endtask

  initial begin
    logic [19:0] a;
    logic [7:0]  d;
    bit wr, aen, hold, both;
    int r;

    vif.bus_a = 20'h0;
    vif.bus_d = 8'h0;
    vif.bus_aen = 1'b0;
    vif.bus_memr_l = 1'b1;
    vif.bus_memw_l = 1'b1;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 8'($urandom);
    ref_mem[15'h0123] = 8'h5A;
    ref_mem[15'h0456] = 8'h3C;

    drive_tick(4);
    preload = 1'b0;
    reset_l = 1'b1;
    @(negedge clk);
    check("reset_rdy", vif.bus_rdy, 1);
    check("reset_we_l", vif.ram_we_l, 1);
    check("reset_bus_out", vif.bus_out, 8'h00);
    check("reset_dir", vif.bus_dir, 0);
    drive_tick(2);

    // Read with wait, slot 10 clocks after the strobe
    rd_addr_q.push_back(15'h0123);
    rd_data_q.push_back(8'h5A);
    rd_held = 1'b1;
    vif.bus_a = 20'hB8123;
    vif.bus_memr_l = 1'b0;
    @(negedge clk);
    check("read_dir", vif.bus_dir, 1);
    repeat (2) @(negedge clk);
    check("rdy_before_detect", vif.bus_rdy, 1);
    @(negedge clk);
    check("rdy_low_3clk", vif.bus_rdy, 0);
    drive_tick(7);
    force_en = 1'b1;
    drive_tick(1);
    force_en = 1'b0;
    wait_rdy(1'b1, 20, "read_rdy_return");
    release_strobes();
    rd_held = 1'b0;
    drive_tick(5);

    // Single-cycle write at the top of the window
    rand_slots = 1'b1;
    issue(1'b1, 20'hBFFFF, 8'hA7, 1'b0, 1'b1, 1'b0);
    rand_slots = 1'b0;

    // Contention: three slots taken by the display, then a free one
    rd_addr_q.push_back(15'h0456);
    rd_data_q.push_back(8'h3C);
    rd_held = 1'b1;
    vif.bus_a = 20'hB8456;
    vif.bus_memr_l = 1'b0;
    drive_tick(5);
    for (int k = 0; k < 3; k++) begin
      force_en = 1'b1;
      force_vr = 1'b1;
      drive_tick(1);
      force_en = 1'b0;
      force_vr = 1'b0;
      drive_tick(3);
      @(negedge clk);
      check("contention_rdy", vif.bus_rdy, 0);
      drive_tick(1);
    end
    force_en = 1'b1;
    drive_tick(1);
    force_en = 1'b0;
    wait_rdy(1'b1, 20, "contention_rdy_return");
    release_strobes();
    rd_held = 1'b0;
    drive_tick(5);

    // Decode misses
    issue(1'b0, 20'hB0000, 8'h00, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 20'hB8000, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset while waiting for a slot, with a slot offered in the reset cycle
    vif.bus_a = 20'hB8010;
    vif.bus_d = 8'hEE;
    vif.bus_memw_l = 1'b0;
    drive_tick(5);
    @(negedge clk);
    check("reset_pre_rdy", vif.bus_rdy, 0);
    drive_tick(1);
    reset_l = 1'b0;
    force_en = 1'b1;
    release_strobes();
    @(negedge clk);
    check("reset_cycle_we_l", vif.ram_we_l, 1);
    drive_tick(1);
    reset_l = 1'b1;
    @(negedge clk);
    check("midreset_rdy", vif.bus_rdy, 1);
    check("midreset_we_l", vif.ram_we_l, 1);
    check("midreset_bus_out", vif.bus_out, 8'h00);
    drive_tick(6);
    force_en = 1'b0;
    drive_tick(2);

    // Early release with no slot pending, then a free slot
    wr_addr_q.push_back(15'h2222);
    wr_data_q.push_back(8'h96);
    ref_mem[15'h2222] = 8'h96;
    vif.bus_a = 20'hBA222;
    vif.bus_d = 8'h96;
    vif.bus_memw_l = 1'b0;
    drive_tick(2);
    release_strobes();
    drive_tick(8);
    @(negedge clk);
    check("early_wait_rdy", vif.bus_rdy, 0);
    drive_tick(1);
    force_en = 1'b1;
    drive_tick(1);
    force_en = 1'b0;
    wait_rdy(1'b1, 20, "early_rdy_back");
    drive_tick(5);

    // Both strobes together count as a write
    rand_slots = 1'b1;
    issue(1'b0, 20'hB9ABC, 8'h5F, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      aen = 1'b0;
      a = {5'b10111, 15'($urandom)};
      if (r == 7) begin
        aen = 1'b1;
      end else if (r > 7) begin
        a = 20'($urandom);
        if (a[19:15] == 5'b10111) a[19] = 1'b0;
      end
      hold = ($urandom_range(0, 3) != 0);
      both = wr && ($urandom_range(0, 5) == 0);
      issue(wr, a, d, aen, hold, both);
    end
    rand_slots = 1'b0;
    drive_tick(4);

    check("wr_queue_drained", wr_addr_q.size(), 0);
    check("rd_queue_drained", rd_addr_q.size(), 0);
    check("rd_data_drained", rd_data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cga_vram_arbiter.md
# cga_vram_arbiter

Arbitrates the single 8-bit video RAM port between CPU (ISA memory) accesses and CGA display fetches. It sits upstream of the CGA display core: it owns `ram_a`/`ram_we_l` and grants the CPU one RAM cycle only in sequencer-designated free slots. It also drives ISA `bus_rdy` wait states so timing-sensitive software sees realistic CGA memory contention.

## Interface
Parameters:
- `FRAMEBUFFER_ADDR`, default 20'hB8000: base of the 32 KB window; decode compares `bus_a[19:15]`.
- `USE_BUS_WAIT`, default 1: if 1, `bus_rdy` is pulled low until the access completes; if 0, `bus_rdy` is tied to 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_l`  in  1  synchronous, active-low reset.
- `bus_a`  in  20  ISA address.
- `bus_memr_l`, `bus_memw_l`  in  1 each  ISA memory strobes, asynchronous.
- `bus_aen`  in  1  DMA address enable; high blocks decode.
- `bus_d`  in  8  ISA write data.
- `bus_out`  out  8  registered read data.
- `bus_dir`  out  1  high while a decoded read strobe is asserted.
- `bus_rdy`  out  1  ISA ready; low inserts wait states.
- `isa_op_enable`  in  1  sequencer free-slot pulse.
- `vram_read`  in  1  high when display owns RAM this cycle.
- `video_addr`  in  19  display fetch address.
- `ram_a`  out  19  RAM address.
- `ram_we_l`  out  1  RAM write enable, active low.
- `ram_dout`  out  8  RAM write data.
- `ram_din`  in  8  RAM read data.

## Operation
- Both memory strobes pass through 2-flop synchronizers. Falling edges are detected on the synced values.
- Chip select: `cs = (bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]) & ~bus_aen`. The select is sampled at the detected falling edge.
- State machine:
  - **IDLE**: on a synced falling edge with `cs`, latch `bus_a[14:0]`, latch `bus_d`, and latch `is_write`, then go to WAIT_SLOT. If both strobes fall in the same cycle, treat the access as a write.
  - **WAIT_SLOT**: grant when `isa_op_enable & ~vram_read`, then go to ACCESS. If `vram_read` and `isa_op_enable` are high together, display wins and the state stays WAIT_SLOT.
  - **ACCESS** (one cycle): for a read, capture `ram_din` into `bus_out`. Go to HOLD.
  - **HOLD**: wait until both synced strobes are high, then go to IDLE.
- RAM mux:
  - In the grant cycle: `ram_a = {4'h0, latched_addr}`; `ram_we_l = ~is_write`; `ram_dout = latched data`.
  - Otherwise: `ram_a = video_addr`; `ram_we_l = 1`.
- `bus_rdy` (when `USE_BUS_WAIT` = 1): registered. It goes 0 the cycle after the edge is detected and returns to 1 on entry to HOLD.
- `bus_dir = cs & ~bus_memr_l` (combinational, raw strobe).
- Strobe released before grant (CPU ignored `bus_rdy`, or `USE_BUS_WAIT` = 0): the latched access still completes. The FSM then passes through HOLD to IDLE. New edges are ignored until IDLE; no access is queued.
- Reset (`reset_l` low at a clk edge, including mid-access):
  - state = IDLE; `bus_rdy` = 1; `ram_we_l` = 1; `bus_out` = 8'h00.
  - Synchronizers are set to 1 (inactive).
  - A pending access is dropped.

## Timing
- Strobe-to-edge detect: 2 clk synchronizer plus 1 clk edge register.
- Grant is possible at the earliest in the first cycle after entering WAIT_SLOT.
- Worst-case wait is bounded by the sequencer slot period (32 clk for a 5-bit `clk_seq`).
- `ram_we_l` is low for exactly one clk per write.
- RAM read latency is 1 clk: `ram_din` is sampled in ACCESS. `bus_out` is valid the cycle HOLD is entered, at the same edge where `bus_rdy` returns to 1.
- Display path: `ram_a` follows `video_addr` combinationally in all non-grant cycles, with zero added latency.

## Test plan
- **Read with wait**: RAM[0x0123]=8'h5A; `bus_memr_l` low at `bus_a`=20'hB8123; slot arrives 10 clk later.
  - `bus_rdy` goes low 3 clk after the strobe.
  - `ram_a`=19'h00123 in the grant cycle.
  - `bus_out`=8'h5A and `bus_rdy`=1 the following clk.
- **Write**: `bus_d`=8'hA7 to 20'hBFFFF.
  - Exactly one clk with `ram_we_l`=0, `ram_a`=19'h07FFF, `ram_dout`=8'hA7.
- **Contention**: `isa_op_enable` and `vram_read` high together for 3 slots, then a free slot.
  - No grant until the free slot; `ram_a` tracks `video_addr` throughout.
- **Decode**: accesses at 20'hB0000, and at 20'hB8000 with `bus_aen`=1.
  - No state change, `bus_rdy` stays 1, `bus_dir`=0.
- **Early release**: write strobe low for 2 clk, then high before any slot.
  - The write still occurs once at the next free slot; the FSM returns to IDLE.
- **Reset mid-operation**: `reset_l` low while in WAIT_SLOT.
  - Next clk: `bus_rdy`=1, `ram_we_l`=1, `bus_out`=8'h00; no RAM write occurs.
